// File: rtl/ext_cpu_obi_arbiter.sv
// Round-robin arbiter sharing one OBI target port among NHARTS cores, with in-order rvalid routing.
// Optional per-core grant counters are enabled by defining EXT_CPU_OBI_ARBITER_PERF_EN.
package ext_cpu_obi_pkg;
    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

module ext_cpu_obi_arbiter
    import ext_cpu_obi_pkg::*;
#(
    parameter int NHARTS          = 3,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  obi_req_t  [NHARTS-1:0]    req_i,
    output obi_resp_t [NHARTS-1:0]    resp_o,
    output obi_req_t                  mst_req_o,
    input  obi_resp_t                 mst_resp_i,
    output logic                      busy_o,
    output logic                      err_o
`ifdef EXT_CPU_OBI_ARBITER_PERF_EN
    ,
    output logic [NHARTS-1:0][15:0]   grant_cnt_o
`endif
);

    localparam int HW  = (NHARTS > 1) ? $clog2(NHARTS) : 1;
    localparam int HW1 = HW + 1;
    localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {ARB, HOLD} state_t;

    state_t          state;
    logic [HW-1:0]   sel_q;
    logic [HW-1:0]   rr_ptr;
    logic [HW-1:0]   sel_idx;
    logic            sel_vld;
    logic [HW-1:0]   id_mem [MAX_OUTSTANDING];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [HW-1:0]   head;
    logic            full;
    logic            handshake;
    logic            pop;
    logic            err;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [HW-1:0] hart_inc(input logic [HW-1:0] h);
        return (h == HW'(NHARTS - 1)) ? '0 : h + 1'b1;
    endfunction

    // In HOLD the stalled requester stays selected so its attributes remain stable until granted
    always_comb begin
        logic [HW1-1:0] idx;
        idx     = '0;
        sel_vld = 1'b0;
        sel_idx = sel_q;
        if (state == HOLD) begin
            sel_vld = req_i[sel_q].req;
        end else begin
            for (int i = 0; i < NHARTS; i++) begin
                idx = {1'b0, rr_ptr} + HW1'(i);
                if (idx >= HW1'(NHARTS)) idx = idx - HW1'(NHARTS);
                if (!sel_vld && req_i[idx[HW-1:0]].req) begin
                    sel_vld = 1'b1;
                    sel_idx = idx[HW-1:0];
                end
            end
        end
    end

    // full comes from the registered count, so a same-cycle pop cannot open a slot
    assign full      = (count == CW'(MAX_OUTSTANDING));
    assign handshake = mst_req_o.req & mst_resp_i.gnt;
    assign pop       = rst_ni & mst_resp_i.rvalid & (count != '0);
    assign head      = id_mem[rd_ptr];

    always_comb begin
        mst_req_o = '0;
        if (sel_vld && !full) begin
            mst_req_o     = req_i[sel_idx];
            mst_req_o.req = 1'b1;
        end
    end

    always_comb begin
        for (int k = 0; k < NHARTS; k++) begin
            resp_o[k].gnt    = handshake & (sel_idx == HW'(k));
            resp_o[k].rvalid = pop & (head == HW'(k));
            resp_o[k].rdata  = mst_resp_i.rdata;
        end
    end

    assign busy_o = rst_ni & ((count != '0) | (state == HOLD));
    assign err_o  = err;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state  <= ARB;
            sel_q  <= '0;
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                ARB: begin
                    if (mst_req_o.req && !mst_resp_i.gnt) begin
                        state <= HOLD;
                        sel_q <= sel_idx;
                    end
                end
                HOLD: begin
                    if (handshake) state <= ARB;
                end
                default: state <= ARB;
            endcase
            if (handshake) begin
                wr_ptr <= ptr_inc(wr_ptr);
                rr_ptr <= hart_inc(sel_idx);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (handshake && !pop) begin
                count <= count + 1'b1;
            end else if (!handshake && pop) begin
                count <= count - 1'b1;
            end
            if (mst_resp_i.rvalid && (count == '0)) err <= 1'b1;
        end
    end

    // ID storage holds data only; validity is tracked by count and pointers
    always_ff @(posedge clk_i) begin
        if (handshake) id_mem[wr_ptr] <= sel_idx;
    end

`ifdef EXT_CPU_OBI_ARBITER_PERF_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            grant_cnt_o <= '0;
        end else begin
            for (int k = 0; k < NHARTS; k++) begin
                if (handshake && (sel_idx == HW'(k)) && (grant_cnt_o[k] != 16'hFFFF)) begin
                    grant_cnt_o[k] <= grant_cnt_o[k] + 16'd1;
                end
            end
        end
    end
`endif

endmodule
